qos_wrr_scheduler: RTL and testbench
====================================

// Module: qos_wrr_scheduler
// PURPOSE
//  Weighted round-robin scheduler that drains the 4 per-class QoS FIFOs (P0..P3) into one shared 12-bit
//  egress path. Sits between the class FIFOs and the destination demux. Pauses on downstream almost-full.
//  Reports idle/active status. Optionally keeps per-class grant counters readable through req/idx.
// PARAMETERS
//  WORD_W   12  data word width
//  WGT_W     4  per-class weight width; weight 0 disables the class
//  CNT_W     8  grant counter width (QOS_CNT_EN only)
// PORTS
//  clk           in   1         single clock; all state updates on its rising edge
//  reset         in   1         synchronous, active-high
//  init          in   1         1 = weights are loaded continuously; no pops are issued
//  weight        in   4*WGT_W   {w3,w2,w1,w0}; sampled only while in INIT
//  empty_in      in   4         class FIFO empty flags, bit k = Pk
//  fifo_data0..3 in   WORD_W    class FIFO read data; valid the cycle after pop
//  pause_in      in   1         OR of destination almost-full flags
//  pop_out       in/out: out 4  one-hot or zero; pop to class FIFO k
//  push_out      out  1         egress word valid
//  data_out      out  WORD_W    egress word
//  active_out    out  1         state == ACTIVE
//  idle_out      out  1         state == IDLE
//  req, idx      in   1, 3      counter read request and index (0..3 valid)
//  valid, data   out  1, CNT_W  counter read response
// BEHAVIOUR
//  Reset: state=RESET; ptr=0, credit=0, latched weights=0, counters=0; all outputs 0. Takes effect mid-operation
//   too: a pop in the reset cycle is discarded and the in-flight push is suppressed.
//  FSM: RESET -(!reset)-> INIT if init else IDLE. INIT -(init=0)-> IDLE.
//   IDLE -(any eligible)-> ACTIVE. ACTIVE -(no eligible)-> IDLE. ACTIVE -(pause_in)-> PAUSE.
//   PAUSE -(!pause_in)-> ACTIVE. From IDLE, ACTIVE or PAUSE: init=1 -> INIT, which drops the current grant.
//  eligible[k] = !empty_in[k] && w[k]!=0.
//  Grant: combinational, evaluated in ACTIVE with !pause_in.
//   If eligible[ptr] && credit<w[ptr]: g=ptr; credit<=credit+1.
//   Else: g = first eligible in order ptr+1..ptr+3 (mod 4); ptr<=g; credit<=1.
//   No eligible class: no grant.
//  There are no bubbles between classes. Exactly one pop per cycle at most. A FIFO flagged empty is never popped.
//  Latency: pop_out[g] in cycle t -> push_out=1 with data_out=fifo_dataG in cycle t+1, regardless of pause_in at t+1.
//   Destination FIFOs therefore need 1 slot of headroom above their high threshold.
//  pause_in=1 forces pop_out=0 in the same cycle. ptr and credit hold.
//  Weights that change outside INIT are ignored. w=15 gives 15 consecutive grants.
// CONFIGURATION
//  QOS_CNT_EN defined: 4 CNT_W grant counters. cnt[g]++ on each pop, wrapping 255->0.
//   req=1 with idx<4 at t -> valid=1, data=cnt[idx] at t+1. idx>=4 or req=0 -> valid=0, data=0.
//   Counters clear only on reset.
//  QOS_CNT_EN undefined: no counters. valid and data are tied to 0; the ports remain.
// STRUCTURE
//  qos_pkg: NUM_CLASS=4, WORD_W, WGT_W, CNT_W, state enum {RESET,INIT,IDLE,ACTIVE,PAUSE}.
//  Sub-module qos_rr_pick: combinational circular first-eligible picker (inputs eligible[3:0], ptr; outputs g, found).
// TESTING
//  1 reset=1 for 2 cycles, then init=1 with weight=16'h1111, then init=0 -> INIT then IDLE;
//    idle_out=1 and all other outputs 0.
//  2 weights {1,1,1,1}, each FIFO holding 2 words -> pop order P0,P1,P2,P3,P0,P1,P2,P3 back-to-back;
//    8 pushes, each one cycle after its pop.
//  3 weights w0=3,w1=1,w2=0,w3=2, all FIFOs deep -> pattern P0,P0,P0,P1,P3,P3 repeats; P2 never popped.
//  4 pause_in=1 for 4 cycles mid-stream -> the in-flight word is pushed; pop_out=0 for 4 cycles;
//    the sequence resumes with the same ptr and credit.
//  5 only P1 non-empty with 1 word -> single pop then IDLE; no pop issued while empty_in[1]=1.
//  6 [QOS_CNT_EN] after test 2, req=1 with idx=0..4 -> data=2,2,2,2 with valid=1, then valid=0 for idx=4;
//    reset mid-stream -> counters 0 and no push.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared constants and FSM state type for the QoS weighted round-robin scheduler.
package qos_pkg;

  localparam int NUM_CLASS = 4;
  localparam int PTR_W     = 2;
  localparam int WORD_W    = 12;
  localparam int WGT_W     = 4;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    S_RESET,
    S_INIT,
    S_IDLE,
    S_ACTIVE,
    S_PAUSE
  } state_t;

endpackage

// File: rtl/qos_rr_pick.sv
// Circular first-eligible picker: searches ptr+1, ptr+2, ptr+3 and finally ptr itself,
// so a lone eligible class whose credit ran out still starts a fresh round.
module qos_rr_pick
  import qos_pkg::*;
(
  input  logic [NUM_CLASS-1:0] eligible,
  input  logic [PTR_W-1:0]     ptr,
  output logic [PTR_W-1:0]     g,
  output logic                 found
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest eligible class wins.
  always_comb begin
    g     = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_CLASS; i >= 1; i--) begin
      cand = ptr + PTR_W'(i);
      if (eligible[cand]) begin
        g     = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin drain of four class FIFOs into one egress path.
// Optional per-class grant counters are built when QOS_CNT_EN is defined.
module qos_wrr_scheduler
  import qos_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [NUM_CLASS*WGT_W-1:0] weight,
  input  logic [NUM_CLASS-1:0]       empty_in,
  input  logic [WORD_W-1:0]          fifo_data0,
  input  logic [WORD_W-1:0]          fifo_data1,
  input  logic [WORD_W-1:0]          fifo_data2,
  input  logic [WORD_W-1:0]          fifo_data3,
  input  logic                       pause_in,
  output logic [NUM_CLASS-1:0]       pop_out,
  output logic                       push_out,
  output logic [WORD_W-1:0]          data_out,
  output logic                       active_out,
  output logic                       idle_out,
  input  logic                       req,
  input  logic [2:0]                 idx,
  output logic                       valid,
  output logic [CNT_W-1:0]           data
);

  state_t                             state;
  logic [NUM_CLASS-1:0][WGT_W-1:0]    wgt;
  logic [NUM_CLASS-1:0][WORD_W-1:0]   fifo_data;
  logic [NUM_CLASS-1:0]               eligible;
  logic [PTR_W-1:0]                   ptr;
  logic [PTR_W-1:0]                   pick_g;
  logic [PTR_W-1:0]                   grant;
  logic [PTR_W-1:0]                   sel_q;
  logic [WGT_W-1:0]                   credit;
  logic                               pick_found;
  logic                               keep;
  logic                               grant_en;
  logic                               push_q;

  assign fifo_data = {fifo_data3, fifo_data2, fifo_data1, fifo_data0};

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      eligible[k] = !empty_in[k] && (wgt[k] != '0);
    end
  end

  qos_rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .g        (pick_g),
    .found    (pick_found)
  );

  // Stay on the current class while it has credit left, otherwise move on.
  assign keep     = eligible[ptr] && (credit < wgt[ptr]);
  assign grant    = keep ? ptr : pick_g;
  assign grant_en = !reset && !init && !pause_in && (state == S_ACTIVE) && (keep || pick_found);
  assign pop_out  = grant_en ? (NUM_CLASS'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RESET;
      wgt    <= '0;
      ptr    <= '0;
      credit <= '0;
      push_q <= 1'b0;
      sel_q  <= '0;
    end else begin
      push_q <= grant_en;
      sel_q  <= grant;
      if (grant_en) begin
        if (keep) begin
          credit <= credit + 1'b1;
        end else begin
          ptr    <= pick_g;
          credit <= WGT_W'(1);
        end
      end
      case (state)
        S_RESET:  state <= init ? S_INIT : S_IDLE;
        // New weights restart the rotation from class 0 with no credit spent.
        S_INIT: begin
          wgt    <= weight;
          ptr    <= '0;
          credit <= '0;
          if (!init) state <= S_IDLE;
        end
        S_IDLE: begin
          if (init)               state <= S_INIT;
          else if (|eligible)     state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (init)               state <= S_INIT;
          else if (pause_in)      state <= S_PAUSE;
          else if (!(|eligible))  state <= S_IDLE;
        end
        S_PAUSE: begin
          if (init)               state <= S_INIT;
          else if (!pause_in)     state <= S_ACTIVE;
        end
        default:                  state <= S_RESET;
      endcase
    end
  end

  // A word popped just before reset is dropped rather than pushed downstream.
  assign push_out   = push_q && !reset;
  assign data_out   = push_out ? fifo_data[sel_q] : '0;
  assign active_out = !reset && (state == S_ACTIVE);
  assign idle_out   = !reset && (state == S_IDLE);

`ifdef QOS_CNT_EN
  logic [NUM_CLASS-1:0][CNT_W-1:0] cnt;
  logic                            valid_q;
  logic [CNT_W-1:0]                data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (grant_en) cnt[grant] <= cnt[grant] + 1'b1;
      valid_q <= req && (idx < 3'd4);
      data_q  <= (req && (idx < 3'd4)) ? cnt[idx[1:0]] : '0;
    end
  end

  assign valid = valid_q && !reset;
  assign data  = reset ? '0 : data_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{req, idx};
  assign valid      = 1'b0;
  assign data       = '0;
`endif

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Directed, table-driven bench for qos_wrr_scheduler with a simple class-FIFO model.
module tb_qos_wrr_scheduler;

`ifdef QOS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        init;
  logic [15:0] weight;
  logic [3:0]  empty_in;
  logic [11:0] fd [4];
  logic        pause_in;
  logic [3:0]  pop_out;
  logic        push_out;
  logic [11:0] data_out;
  logic        active_out;
  logic        idle_out;
  logic        req;
  logic [2:0]  idx;
  logic        valid;
  logic [7:0]  data;

  typedef struct {
    logic        rst;
    logic        ini;
    logic        pau;
    logic        rq;
    logic [2:0]  ix;
    logic [15:0] w;
    int          fill;
    logic [3:0]  e_pop;
    logic        e_push;
    logic [11:0] e_data;
    logic        e_act;
    logic        e_idle;
    logic        e_valid;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t       vecs[$];
  int         tests_run;
  int         tests_failed;
  int         row;
  int         cnt [4];
  int         seq [4];
  logic [3:0] last_pop;
  logic       cv;
  logic [7:0] c2;

  qos_wrr_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .weight     (weight),
    .empty_in   (empty_in),
    .fifo_data0 (fd[0]),
    .fifo_data1 (fd[1]),
    .fifo_data2 (fd[2]),
    .fifo_data3 (fd[3]),
    .pause_in   (pause_in),
    .pop_out    (pop_out),
    .push_out   (push_out),
    .data_out   (data_out),
    .active_out (active_out),
    .idle_out   (idle_out),
    .req        (req),
    .idx        (idx),
    .valid      (valid),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] word(input int k, input int s);
    return 12'((k + 1) * 256 + 16 + s);
  endfunction

  function automatic vec_t mk(input logic r, input logic i, input logic p, input logic q,
                              input logic [2:0] x, input logic [15:0] w, input int f,
                              input logic [3:0] ep, input logic eh, input logic [11:0] ed,
                              input logic ea, input logic ei, input logic ev, input logic [7:0] ec);
    vec_t v;
    v.rst = r; v.ini = i; v.pau = p; v.rq = q; v.ix = x; v.w = w; v.fill = f;
    v.e_pop = ep; v.e_push = eh; v.e_data = ed; v.e_act = ea; v.e_idle = ei;
    v.e_valid = ev; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  // FIFO model: a pop seen last cycle presents its word and lowers the count now.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (last_pop[k]) begin
        fd[k] = word(k, seq[k]);
        seq[k]++;
        if (cnt[k] > 0) cnt[k]--;
      end
      if (v.fill >= 0) cnt[k] = v.fill;
      empty_in[k] = (cnt[k] == 0);
    end
    reset    = v.rst;
    init     = v.ini;
    pause_in = v.pau;
    req      = v.rq;
    idx      = v.ix;
    weight   = v.w;
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    chk("pop_out", 32'(pop_out), 32'(v.e_pop));
    chk("pop_of_empty", 32'(pop_out & empty_in), 32'h0);
    chk("push_out", 32'(push_out), 32'(v.e_push));
    chk("data_out", 32'(data_out), 32'(v.e_data));
    chk("active_out", 32'(active_out), 32'(v.e_act));
    chk("idle_out", 32'(idle_out), 32'(v.e_idle));
    chk("valid", 32'(valid), 32'(v.e_valid));
    chk("data", 32'(data), 32'(v.e_cnt));
    last_pop = pop_out;
    row++;
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; row = 0; last_pop = '0;
    reset = 1'b1; init = 1'b0; weight = '0; empty_in = 4'hF; pause_in = 1'b0;
    req = 1'b0; idx = '0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0; seq[k] = 0; fd[k] = '0;
    end
    cv = CNT_EN;
    c2 = CNT_EN ? 8'd2 : 8'd0;

    // Reset, weight load, then weights 1,1,1,1 with two words per class.
    //                r i p q x  weight    fill  pop    push data     act idle val cnt
    vecs.push_back(mk(1,0,0,0,0, 16'hFFFF, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(1,0,0,0,0, 16'hFFFF, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,1,0,0,0, 16'h1111, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,1,0,0,0, 16'h1111, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'h1111, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0,  2,  4'b0000,0, 12'h000, 0,1,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,0, 12'h000, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0010,1, 12'h110, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0100,1, 12'h210, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h310, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h410, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0010,1, 12'h111, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0100,1, 12'h211, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h311, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0000,1, 12'h411, 1,0,0, 8'h0));
    // Counter reads after two pops per class; index 4 is out of range.
    vecs.push_back(mk(0,0,0,1,0, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,0, 8'h0));
    vecs.push_back(mk(0,0,0,1,1, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,cv, c2));
    vecs.push_back(mk(0,0,0,1,2, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,cv, c2));
    vecs.push_back(mk(0,0,0,1,3, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,cv, c2));
    vecs.push_back(mk(0,0,0,1,4, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,cv, c2));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,0, 8'h0));
    // Weights w0=3 w1=1 w2=0 w3=2 with deep FIFOs: P0,P0,P0,P1,P3,P3 repeating.
    vecs.push_back(mk(0,1,0,0,0, 16'h2013, 100, 4'b0000,0, 12'h000, 0,1,0, 8'h0));
    vecs.push_back(mk(0,1,0,0,0, 16'h2013, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'h2013, -1,  4'b0000,0, 12'h000, 0,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0000,0, 12'h000, 0,1,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,0, 12'h000, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h112, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h113, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0010,1, 12'h114, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h212, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h412, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h413, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h115, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0001,1, 12'h116, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b0010,1, 12'h117, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h213, 1,0,0, 8'h0));
    vecs.push_back(mk(0,0,0,0,0, 16'hF0F0, -1,  4'b1000,1, 12'h414, 1,0,0, 8'h0));

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i]);

    // Pause for 4 cycles right after P3 used its last credit: in-flight word still pushed,
    // then the rotation resumes at P0 (credit was held, so P3 is not granted again).
    runVec(mk(0,0,1,0,0, 16'hF0F0, -1, 4'b0000,1, 12'h415, 1,0,0, 8'h0));
    for (int i = 0; i < 3; i++)
      runVec(mk(0,0,1,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0001,0, 12'h000, 1,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0001,1, 12'h118, 1,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0001,1, 12'h119, 1,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0010,1, 12'h11A, 1,0,0, 8'h0));
    // init mid-stream drops the grant; the last popped word still emerges.
    runVec(mk(0,1,0,0,0, 16'h1111, -1, 4'b0000,1, 12'h214, 1,0,0, 8'h0));

    // Only P1 holds a single word.
    cnt[0] = 0; cnt[1] = 1; cnt[2] = 0; cnt[3] = 0;
    runVec(mk(0,1,0,0,0, 16'h1111, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'h1111, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0010,0, 12'h000, 1,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,1, 12'h215, 1,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,0, 8'h0));

    // Reset right after a pop: no push, counters and weights cleared.
    runVec(mk(0,0,0,0,0, 16'hF0F0, 100, 4'b0000,0, 12'h000, 0,1,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0100,0, 12'h000, 1,0,0, 8'h0));
    runVec(mk(1,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,0,0, 8'h0));
    runVec(mk(0,0,0,1,2, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,0, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,cv, 8'h0));
    runVec(mk(0,0,0,0,0, 16'hF0F0, -1, 4'b0000,0, 12'h000, 0,1,0, 8'h0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
